// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and colour values
package vga_timing_pkg;

  localparam int POS_W = 11;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  // 640x480@60, 25 MHz pixel rate
  localparam int VGA640_H_SYNC  = 96;
  localparam int VGA640_H_BACK  = 48;
  localparam int VGA640_H_DISP  = 640;
  localparam int VGA640_H_FRONT = 16;
  localparam int VGA640_V_SYNC  = 2;
  localparam int VGA640_V_BACK  = 33;
  localparam int VGA640_V_DISP  = 480;
  localparam int VGA640_V_FRONT = 10;

  // 800x600@60, 40 MHz pixel rate
  localparam int SVGA800_H_SYNC  = 128;
  localparam int SVGA800_H_BACK  = 88;
  localparam int SVGA800_H_DISP  = 800;
  localparam int SVGA800_H_FRONT = 40;
  localparam int SVGA800_V_SYNC  = 4;
  localparam int SVGA800_V_BACK  = 23;
  localparam int SVGA800_V_DISP  = 600;
  localparam int SVGA800_V_FRONT = 1;

endpackage

// File: rtl/vga_tick_gen.sv
// rtl/vga_tick_gen.sv - pixel-rate clock enable divided down from the system clock
module vga_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raw h/v counters, sync/active regions and registered VGA pins
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int H_DISP   = VGA640_H_DISP,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter int V_DISP   = VGA640_V_DISP,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       pixel_data,
  output logic [POS_W-1:0] pixel_xpos,
  output logic [POS_W-1:0] pixel_ypos,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [2:0]       vga_rgb,
  output logic             video_de,
  output logic             frame_start
);

  localparam logic [POS_W-1:0] H_LAST    = POS_W'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [POS_W-1:0] H_SYNC_E  = POS_W'(H_SYNC);
  localparam logic [POS_W-1:0] H_ACT_B   = POS_W'(H_SYNC + H_BACK);
  localparam logic [POS_W-1:0] H_ACT_E   = POS_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [POS_W-1:0] V_SYNC_E  = POS_W'(V_SYNC);
  localparam logic [POS_W-1:0] V_ACT_B   = POS_W'(V_SYNC + V_BACK);
  localparam logic [POS_W-1:0] V_ACT_E   = POS_W'(V_SYNC + V_BACK + V_DISP);

  logic             tick;
  logic [POS_W-1:0] h_cnt;
  logic [POS_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             de;

  vga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Regions are decoded in the raw counter frame, sync pulse first.
  assign hs_act = (h_cnt < H_SYNC_E);
  assign vs_act = (v_cnt < V_SYNC_E);
  assign de     = (h_cnt >= H_ACT_B) && (h_cnt < H_ACT_E) &&
                  (v_cnt >= V_ACT_B) && (v_cnt < V_ACT_E);

  assign pixel_xpos = h_cnt;
  assign pixel_ypos = v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs   <= ~SYNC_POL;
      vga_vs   <= ~SYNC_POL;
      vga_rgb  <= BLACK;
      video_de <= 1'b0;
    end else if (tick) begin
      vga_hs   <= hs_act ? SYNC_POL : ~SYNC_POL;
      vga_vs   <= vs_act ? SYNC_POL : ~SYNC_POL;
      vga_rgb  <= de ? pixel_data : BLACK;
      video_de <= de;
    end
  end

  // Clocked every clk so the pulse is one clk wide regardless of CLK_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of divider, sync widths, blanking, latency, frame pulse and reset
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic mode;

  logic [10:0] b_x, b_y, s_x, s_y, c_x, c_y;
  logic        b_hs, b_vs, b_de, b_fs;
  logic        s_hs, s_vs, s_de, s_fs;
  logic        c_hs, c_vs, c_de, c_fs;
  logic [2:0]  b_rgb, s_rgb, c_rgb;
  logic [2:0]  s_pd;

  int n_checks = 0;
  int n_errors = 0;

  // Full 640x480 timing, divide by 2.
  vga_timing_gen u_big (
    .clk(clk), .rst_n(rst_n), .pixel_data(3'b111),
    .pixel_xpos(b_x), .pixel_ypos(b_y), .vga_hs(b_hs), .vga_vs(b_vs),
    .vga_rgb(b_rgb), .video_de(b_de), .frame_start(b_fs)
  );

  // Reduced timing: H 4/3/8/2 (17), V 2/2/5/1 (10), one tick per clk.
  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(5), .V_FRONT(1), .CLK_DIV(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pixel_data(s_pd),
    .pixel_xpos(s_x), .pixel_ypos(s_y), .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_rgb(s_rgb), .video_de(s_de), .frame_start(s_fs)
  );

  // Same reduced timing, divide by 3, to see the one-clk frame pulse.
  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(5), .V_FRONT(1), .CLK_DIV(3)
  ) u_div3 (
    .clk(clk), .rst_n(rst_n), .pixel_data(3'b101),
    .pixel_xpos(c_x), .pixel_ypos(c_y), .vga_hs(c_hs), .vga_vs(c_vs),
    .vga_rgb(c_rgb), .video_de(c_de), .frame_start(c_fs)
  );

  assign s_pd = mode ? s_x[2:0] : 3'b111;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int hp, vp, exp_de, exp_rgb;
    int hs_low, vs_low, de_cnt, white_cnt, blank_leak, win_err, s_fs_cnt, c_fs_cnt, align_err;
    bit found;

    rst_n = 1'b0;
    mode  = 1'b0;
    #22;
    check("rst_b_x",   32'(b_x), 0);
    check("rst_b_y",   32'(b_y), 0);
    check("rst_b_hs",  32'(b_hs), 1);
    check("rst_b_vs",  32'(b_vs), 1);
    check("rst_b_rgb", 32'(b_rgb), 0);
    check("rst_b_de",  32'(b_de), 0);
    check("rst_b_fs",  32'(b_fs), 0);
    check("rst_s_hs",  32'(s_hs), 1);

    // Divider: h advances every second clk, wraps after 1600 clks.
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 1600; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check("div_b_x_k1", 32'(b_x), 0);
        check("div_b_hs_k1", 32'(b_hs), 1);
        check("s_x_k1", 32'(s_x), 1);
        check("s_hs_start", 32'(s_hs), 0);
      end
      if (k == 2) begin
        check("div_b_x_k2", 32'(b_x), 1);
        check("div_b_hs_k2", 32'(b_hs), 0);
      end
      if (k == 4) check("s_hs_last_low", 32'(s_hs), 0);
      if (k == 5) check("s_hs_end", 32'(s_hs), 1);
      if (k == 1598) begin
        check("div_b_x_799", 32'(b_x), 799);
        check("div_b_y_0", 32'(b_y), 0);
      end
      if (k == 1599) check("div_b_x_hold", 32'(b_x), 799);
      if (k == 1600) begin
        check("div_b_x_wrap", 32'(b_x), 0);
        check("div_b_y_inc", 32'(b_y), 1);
      end
    end

    // Full reduced frame with white pixel data, then a frame of h[2:0] data.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    hs_low = 0; vs_low = 0; de_cnt = 0; white_cnt = 0; blank_leak = 0;
    win_err = 0; s_fs_cnt = 0; c_fs_cnt = 0; align_err = 0;
    for (int k = 1; k <= 520; k++) begin
      @(posedge clk); #1;
      hp = (k - 1) % 17;
      vp = ((k - 1) / 17) % 10;
      exp_de = (hp >= 7 && hp < 15 && vp >= 4 && vp < 9) ? 1 : 0;
      if (k <= 170) begin
        if (s_hs == 1'b0) hs_low++;
        if (s_vs == 1'b0) vs_low++;
        if (s_de) de_cnt++;
        if (s_de && s_rgb == 3'b111) white_cnt++;
        if (!s_de && s_rgb != 3'b000) blank_leak++;
        if (32'(s_de) != exp_de) win_err++;
        if (s_fs) s_fs_cnt++;
      end else if (k <= 340) begin
        exp_rgb = exp_de ? (hp % 8) : 0;
        if (32'(s_rgb) != exp_rgb) align_err++;
      end
      if (k == 170) begin
        check("s_fs_at_wrap", 32'(s_fs), 1);
        mode = 1'b1;
      end
      if (c_fs) c_fs_cnt++;
      if (k == 510) check("c_fs_high", 32'(c_fs), 1);
      if (k == 511) check("c_fs_one_clk", 32'(c_fs), 0);
    end
    check("hs_low_ticks", 32'(hs_low), 40);
    check("vs_low_ticks", 32'(vs_low), 34);
    check("de_ticks", 32'(de_cnt), 40);
    check("white_ticks", 32'(white_cnt), 40);
    check("blank_leak", 32'(blank_leak), 0);
    check("de_window_err", 32'(win_err), 0);
    check("s_fs_per_frame", 32'(s_fs_cnt), 1);
    check("c_fs_count", 32'(c_fs_cnt), 1);
    check("latency_align_err", 32'(align_err), 0);

    // Asynchronous reset between clk edges, mid-line inside the active window.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (s_x == 11'd9 && s_y == 11'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("find_pos", 32'(found), 1);
    if (found) begin
      check("pre_rst_de", 32'(s_de), 1);
      #3 rst_n = 1'b0;
      #2;
      check("arst_x", 32'(s_x), 0);
      check("arst_y", 32'(s_y), 0);
      check("arst_de", 32'(s_de), 0);
      check("arst_rgb", 32'(s_rgb), 0);
      check("arst_hs", 32'(s_hs), 1);
      check("arst_vs", 32'(s_vs), 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("restart_s_x", 32'(s_x), 1);
      check("restart_s_y", 32'(s_y), 0);
      check("restart_b_x", 32'(b_x), 0);
      @(posedge clk); #1;
      check("restart_s_x2", 32'(s_x), 2);
      check("restart_b_x2", 32'(b_x), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream timing stage for the character display block: generates raw horizontal/vertical counters and publishes them as pixel_xpos/pixel_ypos.
- Samples the 3-bit pixel_data returned combinationally by the display block and drives the registered VGA pins (vga_hs, vga_vs, vga_rgb), blanked outside the active window.
- Default timing is 640x480@60 (25 MHz pixel rate). An internal clock-enable divider derives the pixel rate from a faster system clock.

Parameters:
- H_SYNC, 96, hsync pulse width (pixel ticks)
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, sync active level (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel tick (1 = every clk; 2 = 50 MHz to 25 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pixel_data  in  3  RGB from display block, combinational function of pixel_xpos/pixel_ypos
- pixel_xpos  out  11  raw horizontal counter h_cnt, 0..H_TOTAL-1
- pixel_ypos  out  11  raw vertical counter v_cnt, 0..V_TOTAL-1
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_rgb  out  3  registered, blanked colour
- video_de  out  1  registered active-video flag, aligned with vga_rgb
- frame_start  out  1  one-clk pulse at frame wrap

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525). All counters are 11 bits.
- Reset (async assert, sync release):
  - div_cnt, h_cnt and v_cnt = 0.
  - vga_hs and vga_vs = inactive (~SYNC_POL).
  - vga_rgb = 0, video_de = 0, frame_start = 0.
- Tick:
  - div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt == CLK_DIV-1).
  - CLK_DIV = 1 gives tick = 1 on every clk.
  - All counter and output registers update only on tick, except frame_start.
- Counters (on tick):
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt wraps.
- Regions (raw counter frame; sync region first):
  - hs_act = h_cnt < H_SYNC.
  - h_act = H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP (144..783).
  - vs_act = v_cnt < V_SYNC.
  - v_act = V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP (35..514).
  - de = h_act & v_act.
- pixel_xpos/pixel_ypos are driven directly from h_cnt/v_cnt registers; 0 cycles from counter.
- Output stage (on tick), one pixel tick latency from counters:
  - vga_hs = hs_act ? SYNC_POL : ~SYNC_POL (same rule for vga_vs with vs_act).
  - video_de = de.
  - vga_rgb = de ? pixel_data : 3'b000.
  - hs, vs, rgb and de stay mutually aligned.
- pixel_data outside the active window is ignored (forced black).
- frame_start = 1 for exactly one clk in the cycle after a tick on which h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1; otherwise 0.
- Reset mid-frame: all state returns to reset values immediately; after release, timing restarts at (0,0) with div_cnt = 0.
- No back-pressure and no handshake: the downstream block must resolve pixel_data combinationally within one clk.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480 and 800x600 timing constant sets
  - colour constants BLACK = 3'b000 and WHITE = 3'b111
  - position width constant POS_W = 11
- Sub-module vga_tick_gen: parameter CLK_DIV; ports clk, rst_n, tick.
- The counter/region/output logic stays in vga_timing_gen.

Test Plan:
- Tick divider: CLK_DIV=2, release reset -> tick every second clk; h_cnt reaches 799 after 1600 clks, then wraps to 0 with v_cnt = 1.
- Sync widths: CLK_DIV=1 -> vga_hs low for 96 ticks per 800-tick line, starting one tick after h_cnt = 0. vga_vs low for 2 lines (1600 ticks) per 525-line frame.
- Active window and blanking: pixel_data tied to 3'b111 -> video_de and vga_rgb = 111 only for registered positions h 144..783, v 35..514. Exactly 307200 de ticks per frame; vga_rgb = 000 elsewhere.
- Latency alignment: pixel_data = h_cnt[2:0] -> vga_rgb at tick n+1 equals h_cnt[2:0] from tick n, within the active window.
- Frame pulse: frame_start is exactly one clk wide, once per 420000 ticks, asserted in the clk after the (799,524) tick.
- Async reset mid-line: assert rst_n low at h_cnt = 400, v_cnt = 200 between clk edges -> outputs go to reset values without waiting for a clk edge; after release, counting restarts from (0,0).
